// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared FSM state and pixel/window types for the window buffer
package cnn_pkg;

  // Frame sequencing: fill the first K-1 rows, stream windows, one idle cycle at frame end
  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } wb_state_e;

  // Default geometry, used by the typedefs below for the common single-channel 3x3 case
  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_K      = 3;
  localparam int unsigned DEF_CH     = 1;

  typedef logic [DEF_CH*DEF_DATA_W-1:0] pixel_t;
  typedef pixel_t [DEF_K-1:0][DEF_K-1:0] window_t;

endpackage

// File: rtl/line_ram.sv
// rtl/line_ram.sv - one image row of storage, single shared write/read address
module line_ram #(
  parameter int unsigned DEPTH = 28,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_i,
  input  logic             i_we,
  input  logic [AW-1:0]    i_addr,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Write on accept; the combinational read returns the older row in the same cycle
  always_ff @(posedge clk_i) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/window_buffer.sv
// rtl/window_buffer.sv - raster pixel stream to K x K sliding windows with stride
module window_buffer
  import cnn_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned K      = 3,
  parameter int unsigned IM_W   = 28,
  parameter int unsigned IM_H   = 28,
  parameter int unsigned CH     = 1,
  parameter int unsigned STRIDE = 1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         s_valid_i,
  output logic                         s_ready_o,
  input  logic [CH*DATA_W-1:0]         s_data_i,
  output logic                         m_valid_o,
  input  logic                         m_ready_i,
  output logic [K*K*CH*DATA_W-1:0]     m_window_o,
  output logic [$clog2(IM_H)-1:0]      m_row_o,
  output logic [$clog2(IM_W)-1:0]      m_col_o,
  output logic                         frame_done_o
);

  localparam int unsigned PIX_W = CH * DATA_W;
  localparam int unsigned CW    = $clog2(IM_W);
  localparam int unsigned RW    = $clog2(IM_H);
  localparam int unsigned PW    = (STRIDE > 1) ? $clog2(STRIDE) : 1;

  wb_state_e r_state, w_state_nxt;

  logic [CW-1:0] r_col, r_ccnt, r_mcol;
  logic [RW-1:0] r_row, r_rcnt, r_mrow;
  logic [PW-1:0] r_cph, r_rph;
  logic          r_valid;

  logic [K-1:0][K-1:0][PIX_W-1:0] r_win;

  logic             w_ready, w_accept, w_emit, w_last_col, w_last_row;
  logic [PIX_W-1:0] w_rd     [K-1];
  logic [PIX_W-1:0] w_wd     [K-1];
  logic [PIX_W-1:0] w_newcol [K];

  assign w_ready    = (r_state != ST_DONE) && (!r_valid || m_ready_i);
  assign w_accept   = s_valid_i && w_ready;
  assign w_last_col = (r_col == CW'(IM_W - 1));
  assign w_last_row = (r_row == RW'(IM_H - 1));
  // Phases are zero exactly on the rows/columns that start an output window
  assign w_emit     = w_accept && (r_state == ST_STREAM) && (r_col >= CW'(K - 1))
                      && (r_cph == '0) && (r_rph == '0);

  // Line memories form a chain: row r-1 in memory 0, row r-2 in memory 1, ...
  for (genvar g = 0; g < K - 1; g++) begin : g_line
    if (g == 0) begin : g_head
      assign w_wd[g] = s_data_i;
    end else begin : g_tail
      assign w_wd[g] = w_rd[g-1];
    end
    line_ram #(
      .DEPTH (IM_W),
      .WIDTH (PIX_W)
    ) u_line_ram (
      .clk_i   (clk_i),
      .i_we    (w_accept),
      .i_addr  (r_col),
      .i_wdata (w_wd[g]),
      .o_rdata (w_rd[g])
    );
    assign w_newcol[K-2-g] = w_rd[g];
  end
  assign w_newcol[K-1] = s_data_i;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: streaming starts after row K-2 completes, DONE lasts one cycle
  always_comb begin
    w_state_nxt  = r_state;
    frame_done_o = 1'b0;
    unique case (r_state)
      ST_FILL: begin
        if (w_accept && w_last_col && (r_row == RW'(K - 2))) w_state_nxt = ST_STREAM;
      end
      ST_STREAM: begin
        if (w_accept && w_last_col && w_last_row) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        frame_done_o = 1'b1;
        w_state_nxt  = ST_FILL;
      end
      default: w_state_nxt = ST_FILL;
    endcase
  end

  // Raster position, stride phases and output-map indices advance on each accepted pixel
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_col  <= '0;
      r_row  <= '0;
      r_cph  <= '0;
      r_rph  <= '0;
      r_ccnt <= '0;
      r_rcnt <= '0;
    end else if (w_accept) begin
      if (w_last_col) begin
        r_col  <= '0;
        r_cph  <= '0;
        r_ccnt <= '0;
        if (w_last_row) begin
          r_row  <= '0;
          r_rph  <= '0;
          r_rcnt <= '0;
        end else begin
          r_row <= r_row + RW'(1);
          if (r_row == RW'(K - 2)) begin
            r_rph  <= '0;
            r_rcnt <= '0;
          end else if (r_row >= RW'(K - 1)) begin
            if (r_rph == PW'(STRIDE - 1)) begin
              r_rph  <= '0;
              r_rcnt <= r_rcnt + RW'(1);
            end else begin
              r_rph <= r_rph + PW'(1);
            end
          end
        end
      end else begin
        r_col <= r_col + CW'(1);
        if (r_col == CW'(K - 2)) begin
          r_cph  <= '0;
          r_ccnt <= '0;
        end else if (r_col >= CW'(K - 1)) begin
          if (r_cph == PW'(STRIDE - 1)) begin
            r_cph  <= '0;
            r_ccnt <= r_ccnt + CW'(1);
          end else begin
            r_cph <= r_cph + PW'(1);
          end
        end
      end
    end
  end

  // Window slides one column left per accept; the new right column is the stored rows plus the input
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_win <= '0;
    end else if (w_accept) begin
      for (int i = 0; i < K; i++) begin
        for (int j = 0; j < K - 1; j++) begin
          r_win[i][j] <= r_win[i][j+1];
        end
        r_win[i][K-1] <= w_newcol[i];
      end
    end
  end

  // Output handshake; accepts only happen when the held window is free or being taken
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid <= 1'b0;
      r_mrow  <= '0;
      r_mcol  <= '0;
    end else if (w_emit) begin
      r_valid <= 1'b1;
      r_mrow  <= r_rcnt;
      r_mcol  <= r_ccnt;
    end else if (m_ready_i) begin
      r_valid <= 1'b0;
    end
  end

  assign s_ready_o  = w_ready;
  assign m_valid_o  = r_valid;
  assign m_window_o = r_win;
  assign m_row_o    = r_mrow;
  assign m_col_o    = r_mcol;

endmodule

// File: tb/tb_window_buffer.sv
// tb/tb_window_buffer.sv - randomized bench for window_buffer against a direct-indexing image model
module tb_window_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid;
  logic [23:0] s_data;
  logic        m_ready;
  int          sel;

  always #5 clk = ~clk;

  logic        a_ready, a_valid, a_done;
  logic [71:0] a_win;
  logic [4:0]  a_row, a_col;
  logic        b_ready, b_valid, b_done;
  logic [71:0] b_win;
  logic [4:0]  b_row, b_col;
  logic        c_ready, c_valid, c_done;
  logic [599:0] c_win;
  logic [2:0]  c_row, c_col;

  window_buffer #(.DATA_W(8), .K(3), .IM_W(28), .IM_H(28), .CH(1), .STRIDE(1)) u_dut_s1 (
    .clk_i(clk), .rst_ni(rst_n), .s_valid_i(s_valid && (sel == 0)), .s_ready_o(a_ready),
    .s_data_i(s_data[7:0]), .m_valid_o(a_valid), .m_ready_i(m_ready), .m_window_o(a_win),
    .m_row_o(a_row), .m_col_o(a_col), .frame_done_o(a_done));

  window_buffer #(.DATA_W(8), .K(3), .IM_W(28), .IM_H(28), .CH(1), .STRIDE(2)) u_dut_s2 (
    .clk_i(clk), .rst_ni(rst_n), .s_valid_i(s_valid && (sel == 1)), .s_ready_o(b_ready),
    .s_data_i(s_data[7:0]), .m_valid_o(b_valid), .m_ready_i(m_ready), .m_window_o(b_win),
    .m_row_o(b_row), .m_col_o(b_col), .frame_done_o(b_done));

  window_buffer #(.DATA_W(8), .K(5), .IM_W(8), .IM_H(8), .CH(3), .STRIDE(1)) u_dut_k5 (
    .clk_i(clk), .rst_ni(rst_n), .s_valid_i(s_valid && (sel == 2)), .s_ready_o(c_ready),
    .s_data_i(s_data), .m_valid_o(c_valid), .m_ready_i(m_ready), .m_window_o(c_win),
    .m_row_o(c_row), .m_col_o(c_col), .frame_done_o(c_done));

  logic         obs_valid, obs_ready, obs_done;
  logic [599:0] obs_win;
  logic [4:0]   obs_row, obs_col;

  always_comb begin
    obs_valid = 1'b0;
    obs_ready = 1'b0;
    obs_done  = 1'b0;
    obs_win   = '0;
    obs_row   = '0;
    obs_col   = '0;
    case (sel)
      0: begin
        obs_valid = a_valid; obs_ready = a_ready; obs_done = a_done;
        obs_win[71:0] = a_win; obs_row = a_row; obs_col = a_col;
      end
      1: begin
        obs_valid = b_valid; obs_ready = b_ready; obs_done = b_done;
        obs_win[71:0] = b_win; obs_row = b_row; obs_col = b_col;
      end
      default: begin
        obs_valid = c_valid; obs_ready = c_ready; obs_done = c_done;
        obs_win = c_win; obs_row = {2'b00, c_row}; obs_col = {2'b00, c_col};
      end
    endcase
  end

  typedef struct {
    logic [599:0] win;
    int           row;
    int           col;
  } exp_t;

  int   n_checks, n_errors;
  int   cf_k, cf_s, cf_w, cf_h, cf_ch;
  logic [23:0] img [28][28];
  exp_t eq [$];
  bit   md_pend, md_done, prev_stall, chk_first, count_rdy;
  int   pr, pc;
  logic [599:0] held_win;
  logic [9:0]   held_rc;
  int   n_win, n_done, n_rdy_low, last_row, last_col;

  task automatic check(input string tag, input logic [599:0] got, input logic [599:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_cfg(input int s);
    sel = s;
    case (s)
      0:       begin cf_k = 3; cf_s = 1; cf_w = 28; cf_h = 28; cf_ch = 1; end
      1:       begin cf_k = 3; cf_s = 2; cf_w = 28; cf_h = 28; cf_ch = 1; end
      default: begin cf_k = 5; cf_s = 1; cf_w = 8;  cf_h = 8;  cf_ch = 3; end
    endcase
  endtask

  // Fill the image, then list every window directly from the output-map coordinates
  task automatic build_frame(input int mode);
    logic [23:0] mask;
    exp_t        e;
    mask = 24'((32'd1 << (8 * cf_ch)) - 32'd1);
    for (int r = 0; r < cf_h; r++)
      for (int c = 0; c < cf_w; c++)
        img[r][c] = (mode == 0) ? 24'((r * 28 + c) % 256) : (24'($urandom()) & mask);
    for (int orow = 0; orow <= (cf_h - cf_k) / cf_s; orow++) begin
      for (int ocol = 0; ocol <= (cf_w - cf_k) / cf_s; ocol++) begin
        e.win = '0;
        e.row = orow;
        e.col = ocol;
        for (int i = 0; i < cf_k; i++)
          for (int j = 0; j < cf_k; j++)
            for (int q = 0; q < cf_ch; q++)
              e.win[((i * cf_k + j) * cf_ch + q) * 8 +: 8] = img[orow * cf_s + i][ocol * cf_s + j][q * 8 +: 8];
        eq.push_back(e);
      end
    end
  endtask

  // One clock: drive at the falling edge, check 1 time unit later, advance the model
  task automatic step(input logic v, input logic [23:0] d, input int duty, output bit acc);
    bit   hs, exp_rdy, emit, last;
    exp_t e;
    s_valid = v;
    s_data  = d;
    m_ready = ($urandom_range(99) < duty);
    #1;
    exp_rdy = !md_done && (!md_pend || m_ready);
    check("m_valid", 600'(obs_valid), 600'(md_pend));
    check("s_ready", 600'(obs_ready), 600'(exp_rdy));
    check("frame_done", 600'(obs_done), 600'(md_done));
    if (obs_done) n_done++;
    if (count_rdy && !obs_ready) n_rdy_low++;
    if (prev_stall) begin
      check("hold_window", obs_win, held_win);
      check("hold_rowcol", 600'({obs_row, obs_col}), 600'(held_rc));
    end
    hs = md_pend && m_ready;
    if (hs) begin
      if (eq.size() == 0) begin
        check("extra_window", 600'(1), 600'(0));
      end else begin
        e = eq.pop_front();
        if (chk_first && n_win == 0)
          check("first_window", obs_win, 600'(72'h3A39381E1D1C020100));
        check("window", obs_win, e.win);
        check("m_row", 600'(obs_row), 600'(e.row));
        check("m_col", 600'(obs_col), 600'(e.col));
        last_row = int'(obs_row);
        last_col = int'(obs_col);
        n_win++;
      end
    end
    prev_stall = md_pend && !m_ready;
    held_win   = obs_win;
    held_rc    = {obs_row, obs_col};
    acc  = v && exp_rdy;
    emit = acc && pr >= cf_k - 1 && pc >= cf_k - 1 &&
           ((pr - cf_k + 1) % cf_s == 0) && ((pc - cf_k + 1) % cf_s == 0);
    last = acc && pr == cf_h - 1 && pc == cf_w - 1;
    md_pend = emit ? 1'b1 : (hs ? 1'b0 : md_pend);
    md_done = last;
    if (acc) begin
      if (pc == cf_w - 1) begin
        pc = 0;
        pr = (pr == cf_h - 1) ? 0 : pr + 1;
      end else begin
        pc++;
      end
    end
    @(negedge clk);
  endtask

  task automatic run_frame(input int mode, input int duty, input int abort_after, input bit gaps);
    int n_acc, cyc;
    bit acc, v;
    build_frame(mode);
    n_acc = 0;
    cyc   = 0;
    while (n_acc < cf_w * cf_h) begin
      if (abort_after > 0 && n_acc >= abort_after) break;
      if (cyc >= 20000) begin
        check("frame_timeout", 600'(0), 600'(1));
        break;
      end
      v = gaps ? ($urandom_range(3) != 0) : 1'b1;
      step(v, img[pr][pc], duty, acc);
      if (acc) n_acc++;
      cyc++;
    end
  endtask

  task automatic drain();
    bit acc;
    for (int i = 0; i < 6; i++) step(1'b0, 24'h0, 100, acc);
  endtask

  task automatic do_reset();
    s_valid = 1'b0;
    m_ready = 1'b1;
    rst_n   = 1'b0;
    #1;
    check("rst_m_valid", 600'(obs_valid), 600'(0));
    check("rst_frame_done", 600'(obs_done), 600'(0));
    check("rst_m_row", 600'(obs_row), 600'(0));
    check("rst_m_col", 600'(obs_col), 600'(0));
    check("rst_s_ready", 600'(obs_ready), 600'(1));
    @(negedge clk);
    @(negedge clk);
    rst_n      = 1'b1;
    md_pend    = 1'b0;
    md_done    = 1'b0;
    prev_stall = 1'b0;
    eq.delete();
    pr = 0;
    pc = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=hang exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    s_valid   = 1'b0;
    s_data    = '0;
    m_ready   = 1'b1;
    chk_first = 1'b0;
    count_rdy = 1'b0;
    n_rdy_low = 0;
    set_cfg(0);
    do_reset();

    n_win = 0; n_done = 0; chk_first = 1'b1;
    run_frame(0, 100, 0, 1'b0);
    drain();
    chk_first = 1'b0;
    check("s1_windows", 600'(n_win), 600'(676));
    check("s1_frame_done", 600'(n_done), 600'(1));
    check("s1_queue_empty", 600'(eq.size()), 600'(0));

    n_win = 0; n_done = 0;
    run_frame(1, 30, 0, 1'b1);
    drain();
    check("stall_windows", 600'(n_win), 600'(676));
    check("stall_frame_done", 600'(n_done), 600'(1));

    run_frame(0, 100, 100, 1'b0);
    do_reset();
    n_win = 0; n_done = 0;
    run_frame(0, 70, 0, 1'b0);
    drain();
    check("rst_windows", 600'(n_win), 600'(676));
    check("rst_frame_done", 600'(n_done), 600'(1));

    n_win = 0; n_done = 0; n_rdy_low = 0; count_rdy = 1'b1;
    run_frame(1, 100, 0, 1'b0);
    run_frame(1, 100, 0, 1'b0);
    count_rdy = 1'b0;
    drain();
    check("b2b_windows", 600'(n_win), 600'(1352));
    check("b2b_frame_done", 600'(n_done), 600'(2));
    check("b2b_ready_low", 600'(n_rdy_low), 600'(1));

    set_cfg(1);
    n_win = 0; n_done = 0;
    run_frame(0, 100, 0, 1'b0);
    drain();
    check("s2_windows", 600'(n_win), 600'(169));
    check("s2_last_row", 600'(last_row), 600'(12));
    check("s2_last_col", 600'(last_col), 600'(12));
    check("s2_frame_done", 600'(n_done), 600'(1));

    set_cfg(2);
    n_win = 0; n_done = 0;
    run_frame(1, 60, 0, 1'b1);
    run_frame(1, 60, 0, 1'b1);
    drain();
    check("k5_windows", 600'(n_win), 600'(32));
    check("k5_frame_done", 600'(n_done), 600'(2));
    check("k5_queue_empty", 600'(eq.size()), 600'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
